// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution: IDLE/RUN/DONE run framing, next-PC
// selection through a loadable branch-target table, and a saturating run-length counter.
module pc_branch_ctrl #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_instr,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             branch_flag,
    input  logic [LUT_W-1:0] target_idx,
    input  logic             lut_wr_en,
    input  logic [LUT_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]  lut_wr_data,
    output logic [PC_W-1:0]  pc_out,
    output logic             fetch_en,
    output logic             branch_taken,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DEPTH = 2 ** LUT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             taken_nxt;
    logic [PC_W-1:0]  lut [DEPTH];
    logic [PC_W-1:0]  lut_rd;

    assign lut_rd   = lut[target_idx];
    assign fetch_en = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_out;
        cnt_nxt   = cycle_count;
        taken_nxt = 1'b0;
        case (state)
            S_RUN: begin
                if (halt_instr) begin
                    state_nxt = S_DONE;
                end else begin
                    // jump and taken branch share the same table lookup
                    if (jump_en || (branch_en && branch_flag)) begin
                        pc_nxt    = lut_rd;
                        taken_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_out + PC_W'(1);
                    end
                    if (cycle_count != '1)
                        cnt_nxt = cycle_count + CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pc_out       <= '0;
            cycle_count  <= '0;
            branch_taken <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc_out       <= pc_nxt;
            cycle_count  <= cnt_nxt;
            branch_taken <= taken_nxt;
        end
    end

    // Table is cleared by reset; the host reloads it before each program.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                lut[i] <= '0;
        end else if (lut_wr_en && state != S_RUN) begin
            lut[lut_wr_idx] <= lut_wr_data;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed scenarios then random traffic, compared against
// a behavioural model; a second instance with a 4-bit counter checks saturation.
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        halt_instr = 1'b0;
    logic        jump_en = 1'b0;
    logic        branch_en = 1'b0;
    logic        branch_flag = 1'b0;
    logic [4:0]  target_idx = '0;
    logic        lut_wr_en = 1'b0;
    logic [4:0]  lut_wr_idx = '0;
    logic [9:0]  lut_wr_data = '0;

    logic [9:0]  pc_out, pc_out_s;
    logic        fetch_en, fetch_en_s;
    logic        branch_taken, branch_taken_s;
    logic        done, done_s;
    logic [15:0] cycle_count;
    logic [3:0]  cycle_count_s;

    int vectors = 0;
    int miscompares = 0;

    // model state: mode 0=idle 1=run 2=done
    int m_mode, m_pc, m_cnt, m_taken;
    int m_tab[32];

    always #5 clk = ~clk;

    pc_branch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt_instr(halt_instr),
        .jump_en(jump_en), .branch_en(branch_en), .branch_flag(branch_flag),
        .target_idx(target_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
        .lut_wr_data(lut_wr_data), .pc_out(pc_out), .fetch_en(fetch_en),
        .branch_taken(branch_taken), .done(done), .cycle_count(cycle_count)
    );

    pc_branch_ctrl #(.PC_W(10), .LUT_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .halt_instr(halt_instr),
        .jump_en(jump_en), .branch_en(branch_en), .branch_flag(branch_flag),
        .target_idx(target_idx), .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
        .lut_wr_data(lut_wr_data), .pc_out(pc_out_s), .fetch_en(fetch_en_s),
        .branch_taken(branch_taken_s), .done(done_s), .cycle_count(cycle_count_s)
    );

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_taken = 0;
        foreach (m_tab[i]) m_tab[i] = 0;
    endtask

    task automatic model_edge();
        m_taken = 0;
        if (m_mode != 1) begin
            if (lut_wr_en) m_tab[lut_wr_idx] = int'(lut_wr_data);
            if (start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
        end else if (halt_instr) begin
            m_mode = 2;
        end else begin
            if (jump_en || (branch_en && branch_flag)) begin
                m_pc = m_tab[target_idx];
                m_taken = 1;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int c16, c4;
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c4  = (m_cnt > 15) ? 15 : m_cnt;
        check("pc_out", int'(pc_out), m_pc);
        check("fetch_en", int'(fetch_en), int'(m_mode == 1));
        check("done", int'(done), int'(m_mode == 2));
        check("branch_taken", int'(branch_taken), m_taken);
        check("cycle_count", int'(cycle_count), c16);
        check("pc_out_cnt4", int'(pc_out_s), m_pc);
        check("cycle_count_cnt4", int'(cycle_count_s), c4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_ctrl();
        start = 0; halt_instr = 0; jump_en = 0; branch_en = 0;
        branch_flag = 0; target_idx = '0; lut_wr_en = 0;
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        #2 reset_n = 1'b1;
    endtask

    task automatic restart();
        idle_ctrl();
        halt_instr = 1; tick();
        halt_instr = 0; start = 1; tick();
        start = 0;
    endtask

    task automatic run_to(input int pc);
        while (m_pc != pc) tick();
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        mid_reset();
        repeat (5) tick();

        // straight-line run 0..7 then halt
        start = 1; tick();
        start = 0; repeat (7) tick();
        halt_instr = 1; tick();
        check("halt_pc_7", int'(pc_out), 7);
        check("halt_cnt_7", int'(cycle_count), 7);
        halt_instr = 0; tick();

        // table[3]=0x040 loaded in DONE; taken branch at pc 5
        lut_wr_en = 1; lut_wr_idx = 5'd3; lut_wr_data = 10'h040; tick();
        lut_wr_en = 0;
        start = 1; tick(); start = 0;
        run_to(5);
        branch_en = 1; target_idx = 5'd3; branch_flag = 1; tick();
        check("branch_to_040", int'(pc_out), 'h40);
        idle_ctrl(); tick();

        // not-taken branch at pc 5
        restart();
        run_to(5);
        branch_en = 1; target_idx = 5'd3; branch_flag = 0; tick();
        check("nottaken_pc6", int'(pc_out), 6);
        idle_ctrl(); tick();

        // halt beats jump at pc 2
        restart();
        run_to(2);
        halt_instr = 1; jump_en = 1; target_idx = 5'd3; tick();
        check("halt_prio_pc2", int'(pc_out), 2);
        idle_ctrl();

        // write during RUN is ignored; jump still lands on 0x040
        start = 1; tick(); start = 0;
        lut_wr_en = 1; lut_wr_idx = 5'd3; lut_wr_data = 10'h3FF; tick();
        lut_wr_en = 0; jump_en = 1; target_idx = 5'd3; tick();
        check("lockout_040", int'(pc_out), 'h40);
        idle_ctrl();

        // wrap from 0x3FF to 0 and 4-bit counter saturation
        halt_instr = 1; tick(); halt_instr = 0;
        lut_wr_en = 1; lut_wr_idx = 5'd0; lut_wr_data = 10'h3FE; tick();
        lut_wr_en = 0; start = 1; tick(); start = 0;
        jump_en = 1; target_idx = 5'd0; tick();
        jump_en = 0; tick(); tick();
        check("wrap_to_0", int'(pc_out), 0);
        repeat (20) tick();
        check("sat_cnt4", int'(cycle_count_s), 15);

        // restart from DONE, then reset mid-run clears the table
        halt_instr = 1; tick(); halt_instr = 0;
        start = 1; tick(); start = 0;
        repeat (3) tick();
        mid_reset();
        start = 1; tick(); start = 0;
        jump_en = 1; target_idx = 5'd3; tick();
        check("cleared_tab3", int'(pc_out), 0);
        idle_ctrl();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            start       = ($urandom_range(0, 2) == 0);
            halt_instr  = ($urandom_range(0, 24) == 0);
            jump_en     = ($urandom_range(0, 9) == 0);
            branch_en   = ($urandom_range(0, 4) == 0);
            branch_flag = 1'($urandom);
            target_idx  = 5'($urandom);
            lut_wr_en   = ($urandom_range(0, 3) == 0);
            lut_wr_idx  = 5'($urandom);
            lut_wr_data = 10'($urandom);
            tick();
            if (n == 200) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and branch-resolution stage downstream of the ALU.
- Each cycle it consumes the ALU's branch flag and the decoder's control bits, and computes the next instruction address.
- Taken branches and jumps are redirected through a small loadable branch-target lookup table.
- A start/done handshake with the testbench/host frames each program run, and a cycle counter reports run length.

Parameters:
- PC_W, 10, width of program counter / instruction address.
- LUT_W, 5, width of branch-target index; table depth is 2**LUT_W.
- CNT_W, 16, width of cycle counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  run request from host; sampled in IDLE/DONE.
- halt_instr  in  1  decoder: current instruction is HALT.
- jump_en  in  1  decoder: current instruction is an unconditional jump.
- branch_en  in  1  decoder: current instruction is a conditional branch.
- branch_flag  in  1  ALU compare result (lt/gt/eq) for the current instruction.
- target_idx  in  LUT_W  branch-target table index from the instruction.
- lut_wr_en  in  1  table write strobe (program-load time only).
- lut_wr_idx  in  LUT_W  table write index.
- lut_wr_data  in  PC_W  table write data (absolute target address).
- pc_out  out  PC_W  current instruction address (registered).
- fetch_en  out  1  high while RUN; instruction memory output valid.
- branch_taken  out  1  one-cycle pulse after a redirect.
- done  out  1  high in DONE state.
- cycle_count  out  CNT_W  cycles spent in RUN for the current or last run.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, pc_out=0, fetch_en=0, branch_taken=0, done=0, cycle_count=0, all table entries=0.
- States: IDLE, RUN, DONE. fetch_en=1 only in RUN; done=1 only in DONE (both decoded from the state register).
- IDLE/DONE with start=1: at the next edge go to RUN, pc_out<=0, cycle_count<=0, branch_taken<=0. done drops at that same edge.
- IDLE/DONE with start=0: hold state; pc_out and cycle_count hold.
- RUN timing: the instruction at pc_out is decoded and executed combinationally in the same cycle. Control inputs and branch_flag are sampled at the next rising edge.
- RUN next-PC priority, highest first:
  1. halt_instr=1: go to DONE, pc_out holds (points at HALT), no count increment on this edge.
  2. jump_en=1: pc_out <= table[target_idx].
  3. branch_en=1 and branch_flag=1: pc_out <= table[target_idx].
  4. Otherwise (including branch_en=1 with branch_flag=0): pc_out <= pc_out+1, modulo 2**PC_W (1023 wraps to 0).
- branch_taken is registered. It is 1 in the cycle after an edge that took case 2 or 3, and 0 otherwise.
- cycle_count increments by 1 on every RUN edge that does not halt. It saturates at 2**CNT_W-1 and holds its value through DONE.
- start is ignored while in RUN.
- Table writes: when lut_wr_en=1 and state is not RUN, table[lut_wr_idx] <= lut_wr_data at the edge. Writes are ignored in RUN.
- Table read is combinational on target_idx.
- reset_n low mid-run: immediate return to all reset values, including clearing the table. The host must reload the table after reset.
- Simultaneous jump_en and branch_en: jump wins; the result is identical because both use target_idx.

Test Plan:
- Reset then idle: assert reset_n=0 mid-cycle -> pc_out=0, done=0, fetch_en=0 immediately; with start=0 for 5 cycles all outputs hold.
- Straight-line run: load nothing, pulse start, hold controls 0 for 7 cycles, then halt_instr=1 -> pc_out steps 0..7, done=1 next edge, cycle_count=7, pc_out stays 7.
- Conditional branch: table[3]=0x040 written in IDLE. In RUN at pc_out=5 with branch_en=1, target_idx=3:
  - branch_flag=1 -> pc_out=0x040, branch_taken=1 for one cycle.
  - Repeated with branch_flag=0 -> pc_out=6, branch_taken=0.
- Priority and table lockout: at pc_out=2, halt_instr=jump_en=1 -> DONE, pc_out=2. Separately, a lut_wr_en in RUN to idx 3 with data 0x3FF leaves table[3]=0x040 (a later jump lands at 0x040).
- Wrap and saturation: table[0]=0x3FE, jump via idx 0, controls idle -> pc_out 0x3FE, 0x3FF, 0x000. With CNT_W overridden to 4, 20 RUN cycles -> cycle_count=15.
- Restart and mid-run reset: from DONE, start=1 -> RUN with pc_out=0, cycle_count=0, done=0 at the same edge. Asserting reset_n=0 during RUN -> IDLE, table[3] reads 0.
